// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_pkg
//  Description : Shared constants for the seven-segment scan controller:
//                active-low segment patterns and the scan state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package seven_seg_pkg;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_D0    = 7'h40;
    localparam logic [6:0] SEG_D1    = 7'h79;
    localparam logic [6:0] SEG_D2    = 7'h24;
    localparam logic [6:0] SEG_D3    = 7'h30;
    localparam logic [6:0] SEG_D4    = 7'h19;
    localparam logic [6:0] SEG_D5    = 7'h12;
    localparam logic [6:0] SEG_D6    = 7'h02;
    localparam logic [6:0] SEG_D7    = 7'h78;
    localparam logic [6:0] SEG_D8    = 7'h00;
    localparam logic [6:0] SEG_D9    = 7'h10;

    // Each digit slot starts blanked, then shows the digit.
    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/bcd_seg_dec.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seg_dec
//  Description : Combinational BCD nibble to active-low 7-segment decoder.
//                Non-decimal codes (10..15) produce a blank digit.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_seg_dec
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup; anything outside 0..9 is shown as blank.
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'd0:    seg = SEG_D0;
            4'd1:    seg = SEG_D1;
            4'd2:    seg = SEG_D2;
            4'd3:    seg = SEG_D3;
            4'd4:    seg = SEG_D4;
            4'd5:    seg = SEG_D5;
            4'd6:    seg = SEG_D6;
            4'd7:    seg = SEG_D7;
            4'd8:    seg = SEG_D8;
            4'd9:    seg = SEG_D9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule : bcd_seg_dec
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan_ctrl
//  Description : Time-multiplexed scan controller for an N-digit common-anode
//                7-segment display. Shares one decoder across all digits,
//                inserts a blanking gap at the start of every digit slot and
//                swaps in newly loaded values only at frame boundaries.
//  Revision    : 1.0  initial release
// ============================================================================
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*N_DIGITS-1:0]   load_data,
    input  logic [N_DIGITS-1:0]     load_dp,
    input  logic                    lz_blank_en,
    output logic [N_DIGITS-1:0]     an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(N_DIGITS - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;

    logic [4*N_DIGITS-1:0]   r_act_data;
    logic [N_DIGITS-1:0]     r_act_dp;
    logic [4*N_DIGITS-1:0]   r_pend_data;
    logic [N_DIGITS-1:0]     r_pend_dp;
    logic                    r_pend_full;
    logic                    r_boundary_d;

    logic                    w_slot_end;
    logic                    w_boundary;
    logic                    w_xfer;
    logic [3:0]              w_nib;
    logic [6:0]              w_dec_seg;
    logic                    w_dp_sel;
    logic [N_DIGITS-1:0]     w_hi_zero;
    logic                    w_lz_blank;
    logic [N_DIGITS-1:0]     w_an_sel;

    assign w_slot_end = (r_state == S_SHOW) && (r_cnt == CNT_LAST);
    assign w_boundary = w_slot_end && (r_idx == IDX_LAST);
    assign w_xfer     = load_valid & ~r_pend_full;
    assign load_ready = ~r_pend_full;

    // Scan state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_BLANK;
        else        r_state <= w_state_next;
    end

    // Blank gap ends after BLANK_CYC cycles; the show phase ends with the slot.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_BLANK: if (r_cnt == CNT_BLANK_LAST) w_state_next = S_SHOW;
            S_SHOW:  if (w_slot_end)              w_state_next = S_BLANK;
            default: w_state_next = S_BLANK;
        endcase
    end

    // Slot counter and digit index; the index advances at each slot end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Pending buffer takes loads; active copy only changes at a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_data  <= '0;
            r_act_dp    <= '0;
            r_pend_data <= '0;
            r_pend_dp   <= '0;
            r_pend_full <= 1'b0;
        end else begin
            if (w_boundary && r_pend_full) begin
                r_act_data  <= r_pend_data;
                r_act_dp    <= r_pend_dp;
                r_pend_full <= 1'b0;
            end
            // A transfer needs pend_full=0, so it never collides with the swap.
            if (w_xfer) begin
                r_pend_data <= load_data;
                r_pend_dp   <= load_dp;
                r_pend_full <= 1'b1;
            end
        end
    end

    // w_hi_zero[k] is set when active nibbles N-1..k are all zero.
    always_comb begin
        logic v_run;
        v_run     = 1'b1;
        w_hi_zero = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            v_run        = v_run & (r_act_data[4*k +: 4] == 4'd0);
            w_hi_zero[k] = v_run;
        end
    end

    assign w_nib      = r_act_data[4*r_idx +: 4];
    assign w_dp_sel   = r_act_dp[r_idx];
    assign w_lz_blank = lz_blank_en && (r_idx != '0) && w_hi_zero[r_idx];

    // Active-low one-hot anode for the digit currently being scanned.
    always_comb begin
        w_an_sel        = '1;
        w_an_sel[r_idx] = 1'b0;
    end

    bcd_seg_dec u_dec (
        .nibble (w_nib),
        .seg    (w_dec_seg)
    );

    // Registered display outputs, one cycle behind the scan state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (r_state == S_BLANK) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= w_an_sel;
            seg <= w_lz_blank ? SEG_BLANK : w_dec_seg;
            dp  <= ~w_dp_sel;
        end
    end

    // Two-stage delay lines frame_done up with the first blank output of digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_boundary_d <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            r_boundary_d <= w_boundary;
            frame_done   <= r_boundary_d;
        end
    end

endmodule : seven_seg_scan_ctrl
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scan_ctrl
//  Description : Self-checking bench for seven_seg_scan_ctrl. A position-based
//                reference model predicts every output cycle into a queue; a
//                monitor pops and compares on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seven_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int RD    = 8;
    localparam int BL    = 2;
    localparam int FRAME = N * RD;

    localparam logic [6:0] TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic           clk = 1'b0;
    logic           rst_n;
    logic           load_valid;
    logic           load_ready;
    logic [4*N-1:0] load_data;
    logic [N-1:0]   load_dp;
    logic           lz_blank_en;
    logic [N-1:0]   an;
    logic [6:0]     seg;
    logic           dp;
    logic           frame_done;

    seven_seg_scan_ctrl #(
        .N_DIGITS    (N),
        .REFRESH_DIV (RD),
        .BLANK_CYC   (BL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_dp     (load_dp),
        .lz_blank_en (lz_blank_en),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic       rdy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // p counts cycles since reset release; the digit and the position within
    // its slot follow directly from p.
    int       p;
    bit [3:0] act  [N];
    bit [3:0] pend [N];
    bit       actdp [N];
    bit       penddp[N];
    bit       pfull;
    bit       prev_b;
    int       m_dig, m_off;
    bit       m_b, m_zero;
    exp_t     e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p = 0; pfull = 0; prev_b = 0;
            for (int j = 0; j < N; j++) begin
                act[j] = 0; pend[j] = 0; actdp[j] = 0; penddp[j] = 0;
            end
            q.delete();
        end else begin
            m_dig = (p / RD) % N;
            m_off = p % RD;
            if (m_off < BL) begin
                e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
            end else begin
                e.an = ~(4'b0001 << m_dig);
                m_zero = 1;
                for (int j = m_dig; j < N; j++) if (act[j] != 0) m_zero = 0;
                if ((lz_blank_en && m_dig != 0 && m_zero) || act[m_dig] > 9)
                    e.seg = 7'h7F;
                else
                    e.seg = TAB[act[m_dig]];
                e.dp = ~actdp[m_dig];
            end
            e.fd = prev_b;
            m_b  = (m_off == RD - 1) && (m_dig == N - 1);
            if (m_b && pfull) begin
                for (int j = 0; j < N; j++) begin act[j] = pend[j]; actdp[j] = penddp[j]; end
                pfull = 0;
            end else if (load_valid && !pfull) begin
                for (int j = 0; j < N; j++) begin pend[j] = load_data[4*j +: 4]; penddp[j] = load_dp[j]; end
                pfull = 1;
            end
            e.rdy  = !pfull;
            prev_b = m_b;
            q.push_back(e);
            p++;
        end
    end

    // ---------------- monitor ----------------
    exp_t got;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_an", 32'(an), 32'hF);
            chk("rst_seg", 32'(seg), 32'h7F);
            chk("rst_dp", 32'(dp), 32'h1);
            chk("rst_fd", 32'(frame_done), 32'h0);
            chk("rst_ready", 32'(load_ready), 32'h1);
        end else if (q.size() == 0) begin
            chk("queue_underflow", 32'(q.size()), 32'h1);
        end else begin
            got = q.pop_front();
            chk("an", 32'(an), 32'(got.an));
            chk("seg", 32'(seg), 32'(got.seg));
            chk("dp", 32'(dp), 32'(got.dp));
            chk("frame_done", 32'(frame_done), 32'(got.fd));
            chk("load_ready", 32'(load_ready), 32'(got.rdy));
        end
    end

    // ---------------- stimulus ----------------
    task automatic load_once(input logic [15:0] d, input logic [3:0] pdp);
        load_valid = 1'b1; load_data = d; load_dp = pdp;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; load_valid = 1'b0; load_data = '0; load_dp = '0; lz_blank_en = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // idle scan of zeros
        repeat (70) @(negedge clk);
        load_once(16'h1234, 4'b0000);
        repeat (70) @(negedge clk);

        // leading-zero blanking on and off
        lz_blank_en = 1'b1;
        load_once(16'h0050, 4'b0000);
        repeat (70) @(negedge clk);
        lz_blank_en = 1'b0;
        repeat (40) @(negedge clk);

        // non-decimal nibble with a decimal point on digit 0
        load_once(16'h000B, 4'b0001);
        repeat (70) @(negedge clk);

        // valid held while pending is full: only the first word is taken
        load_valid = 1'b1; load_data = 16'h9876; load_dp = 4'b1010;
        @(negedge clk);
        load_data = 16'h5555; load_dp = 4'b0101;
        repeat (8) @(negedge clk);
        load_valid = 1'b0;
        repeat (70) @(negedge clk);

        // single-cycle load exactly in the frame-boundary cycle
        guard = 0;
        while ((p % FRAME) != FRAME - 1 && guard < 2 * FRAME) begin
            @(negedge clk); guard++;
        end
        chk("boundary_wait", 32'(p % FRAME), 32'(FRAME - 1));
        load_once(16'h4321, 4'b0100);
        repeat (100) @(negedge clk);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            load_valid = ($urandom_range(0, 5) == 0);
            load_data  = 16'($urandom);
            if ($urandom_range(0, 1) == 1) load_data[15:8] = 8'h00;
            if ($urandom_range(0, 3) == 0) load_data[7:4]  = 4'h0;
            load_dp    = 4'($urandom);
            if ($urandom_range(0, 9) == 0) lz_blank_en = ~lz_blank_en;
            @(negedge clk);
        end
        load_valid = 1'b0;

        // asynchronous reset while digit 2 is lit
        guard = 0;
        while (an !== 4'hB && guard < 3 * FRAME) begin
            @(negedge clk); guard++;
        end
        chk("an_B_wait", 32'(an), 32'hB);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", 32'(an), 32'hF);
        chk("async_seg", 32'(seg), 32'h7F);
        chk("async_dp", 32'(dp), 32'h1);
        chk("async_ready", 32'(load_ready), 32'h1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (80) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seven_seg_scan_ctrl
`default_nettype wire
